// File: rtl/stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall controller.
// EX bus layout follows `EX_BUS_W (default 38).
`ifndef EX_BUS_W
`define EX_BUS_W 38
`endif

package stall_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    DIV_BUSY  = 2'd2
  } state_t;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_LOAD = 6'b000111;
  localparam logic [5:0] STALL_DIV  = 6'b001111;

  localparam int EX_BUS_W  = `EX_BUS_W;
  localparam int EX_WE_BIT = EX_BUS_W - 1;
  localparam int EX_WA_LO  = EX_BUS_W - 6;

  typedef struct packed {
    logic       we;
    logic [4:0] waddr;
  } ex_wr_t;

  function automatic logic rd_match(
    input logic       re,
    input logic [4:0] ra,
    input logic [4:0] wa
  );
    return re && (ra == wa);
  endfunction

endpackage

// File: rtl/stall_ctrl_hazard_detect.sv
// Load-use compare between ID read ports and the EX load.
// Purely combinational so a second ID slot can reuse it.
module hazard_detect
  import stall_ctrl_pkg::*;
(
  input  logic       id_re1,
  input  logic [4:0] id_raddr1,
  input  logic       id_re2,
  input  logic [4:0] id_raddr2,
  input  ex_wr_t     ex_wr,
  input  logic       ex_is_load,
  output logic       hazard
);

  logic rd_hit;

  assign rd_hit = rd_match(id_re1, id_raddr1, ex_wr.waddr)
                | rd_match(id_re2, id_raddr2, ex_wr.waddr);

  assign hazard = ex_is_load & ex_wr.we
                & (ex_wr.waddr != 5'd0) & rd_hit;

endmodule

// File: rtl/stall_ctrl.sv
// Load-use and multi-cycle divide stall controller.
// Optional STALL_PERF_EN adds stall cycle counters.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned DIV_TIMEOUT  = 40,
  parameter int unsigned CNT_W        = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_re1,
  input  logic [4:0] id_raddr1,
  input  logic       id_re2,
  input  logic [4:0] id_raddr2,
  input  logic       ex_we,
  input  logic [4:0] ex_waddr,
  input  logic       ex_is_load,
  input  logic       ex_div_req,
  input  logic       div_ready,
  input  logic       flush,
  output logic [5:0] stall,
  output logic       div_start,
  output logic       div_cancel,
  output logic       div_err
`ifdef STALL_PERF_EN
  ,
  output logic [31:0] perf_load_cyc,
  output logic [31:0] perf_div_cyc
`endif
);

  if (LOAD_BUBBLES < 1 || LOAD_BUBBLES > 7) begin : g_bad_lb
    $error("LOAD_BUBBLES must be 1..7");
  end
  if (DIV_TIMEOUT < 33) begin : g_bad_to
    $error("DIV_TIMEOUT must be >= 33");
  end
  if (DIV_TIMEOUT >= (1 << CNT_W)) begin : g_bad_cw
    $error("CNT_W too narrow for DIV_TIMEOUT");
  end
  if (EX_WE_BIT - EX_WA_LO != 5) begin : g_bad_bus
    $error("EX bus write field layout mismatch");
  end

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(DIV_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LB_INIT = CNT_W'(LOAD_BUBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             err_set;
  logic             hazard;
  logic [5:0]       stall_r;
  logic             start_r;
  logic             cancel_r;

  logic [EX_WE_BIT:EX_WA_LO] ex_slice;
  ex_wr_t                    ex_wr;

  assign ex_slice = {ex_we, ex_waddr};
  assign ex_wr    = ex_wr_t'(ex_slice);

  hazard_detect u_hazard (
    .id_re1     (id_re1),
    .id_raddr1  (id_raddr1),
    .id_re2     (id_re2),
    .id_raddr2  (id_raddr2),
    .ex_wr      (ex_wr),
    .ex_is_load (ex_is_load),
    .hazard     (hazard)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      div_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (err_set) div_err <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (!flush) begin
          if (ex_div_req) begin
            state_n = DIV_BUSY;
            cnt_n   = '0;
          end else if (hazard && LOAD_BUBBLES > 1) begin
            state_n = LOAD_WAIT;
            cnt_n   = LB_INIT;
          end
        end
      end
      LOAD_WAIT: begin
        if (cnt != '0) cnt_n = cnt - CNT_ONE;
        if (flush || cnt <= CNT_ONE) state_n = IDLE;
      end
      DIV_BUSY: begin
        if (cnt != '1) cnt_n = cnt + CNT_ONE;
        if (flush || div_ready) begin
          state_n = IDLE;
        end else if (cnt == TO_LAST) begin
          state_n = IDLE;
          err_set = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    stall_r  = STALL_NONE;
    start_r  = 1'b0;
    cancel_r = 1'b0;
    unique case (state)
      IDLE: begin
        if (!flush) begin
          if (ex_div_req) begin
            start_r = 1'b1;
            stall_r = STALL_DIV;
          end else if (hazard) begin
            stall_r = STALL_LOAD;
          end
        end
      end
      LOAD_WAIT: begin
        if (!flush) stall_r = STALL_LOAD;
      end
      DIV_BUSY: begin
        if (flush) begin
          cancel_r = 1'b1;
        end else if (!div_ready) begin
          if (cnt == TO_LAST) cancel_r = 1'b1;
          else stall_r = STALL_DIV;
        end
      end
      default: ;
    endcase
  end

  // Held low through reset even if ID/EX still show a hazard or divide.
  assign stall      = rst_n ? stall_r : STALL_NONE;
  assign div_start  = rst_n & start_r;
  assign div_cancel = rst_n & cancel_r;

`ifdef STALL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_load_cyc <= '0;
      perf_div_cyc  <= '0;
    end else begin
      if (stall == STALL_LOAD && perf_load_cyc != '1)
        perf_load_cyc <= perf_load_cyc + 32'd1;
      if (stall == STALL_DIV && perf_div_cyc != '1)
        perf_div_cyc <= perf_div_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Scoreboard bench for stall_ctrl: two parameterisations
// driven in lockstep against a behavioural model.
module tb_stall_ctrl;
  import stall_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_re1, id_re2;
  logic [4:0] id_raddr1, id_raddr2;
  logic       ex_we, ex_is_load, ex_div_req;
  logic [4:0] ex_waddr;
  logic       div_ready, flush;

  logic [5:0] stall0, stall1;
  logic       st0, st1, cn0, cn1, er0, er1;
`ifdef STALL_PERF_EN
  logic [31:0] pl0, pd0, pl1, pd1;
`endif

  always #5 clk = ~clk;

  stall_ctrl u0 (
    .clk(clk), .rst_n(rst_n),
    .id_re1(id_re1), .id_raddr1(id_raddr1),
    .id_re2(id_re2), .id_raddr2(id_raddr2),
    .ex_we(ex_we), .ex_waddr(ex_waddr),
    .ex_is_load(ex_is_load), .ex_div_req(ex_div_req),
    .div_ready(div_ready), .flush(flush),
    .stall(stall0), .div_start(st0),
    .div_cancel(cn0), .div_err(er0)
`ifdef STALL_PERF_EN
    , .perf_load_cyc(pl0), .perf_div_cyc(pd0)
`endif
  );

  stall_ctrl #(.LOAD_BUBBLES(3), .DIV_TIMEOUT(35)) u1 (
    .clk(clk), .rst_n(rst_n),
    .id_re1(id_re1), .id_raddr1(id_raddr1),
    .id_re2(id_re2), .id_raddr2(id_raddr2),
    .ex_we(ex_we), .ex_waddr(ex_waddr),
    .ex_is_load(ex_is_load), .ex_div_req(ex_div_req),
    .div_ready(div_ready), .flush(flush),
    .stall(stall1), .div_start(st1),
    .div_cancel(cn1), .div_err(er1)
`ifdef STALL_PERF_EN
    , .perf_load_cyc(pl1), .perf_div_cyc(pd1)
`endif
  );

  typedef struct {
    logic [5:0] stall;
    logic       start;
    logic       cancel;
    logic       err;
    int         pl;
    int         pd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t a, b;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;
  int mcyc  = 0;

  // Model state: remaining load bubbles, age of the divide in flight.
  int lw_left[2] = '{0, 0};
  int div_age[2] = '{-1, -1};
  bit err_m[2]   = '{1'b0, 1'b0};
  int pl_m[2]    = '{0, 0};
  int pd_m[2]    = '{0, 0};
  int LBv[2]     = '{1, 3};
  int TOv[2]     = '{40, 35};

  task automatic model(input int k, input bit rn, input bit haz,
                       input bit dr, input bit rdy, input bit fl,
                       output exp_t e);
    e.stall  = 6'b0;
    e.start  = 1'b0;
    e.cancel = 1'b0;
    e.err    = err_m[k];
    e.pl     = pl_m[k];
    e.pd     = pd_m[k];
    if (!rn) begin
      lw_left[k] = 0;
      div_age[k] = -1;
      err_m[k]   = 1'b0;
      pl_m[k]    = 0;
      pd_m[k]    = 0;
      e.err      = 1'b0;
      e.pl       = 0;
      e.pd       = 0;
      return;
    end
    if (div_age[k] >= 0) begin
      if (fl) begin
        e.cancel   = 1'b1;
        div_age[k] = -1;
      end else if (rdy) begin
        div_age[k] = -1;
      end else if (div_age[k] == TOv[k] - 1) begin
        e.cancel   = 1'b1;
        err_m[k]   = 1'b1;
        div_age[k] = -1;
      end else begin
        e.stall = STALL_DIV;
        div_age[k]++;
      end
    end else if (lw_left[k] > 0) begin
      if (fl) lw_left[k] = 0;
      else begin
        e.stall = STALL_LOAD;
        lw_left[k]--;
      end
    end else if (!fl) begin
      if (dr) begin
        e.start    = 1'b1;
        e.stall    = STALL_DIV;
        div_age[k] = 0;
      end else if (haz) begin
        e.stall    = STALL_LOAD;
        lw_left[k] = LBv[k] - 1;
      end
    end
    if (e.stall == STALL_LOAD) pl_m[k]++;
    if (e.stall == STALL_DIV)  pd_m[k]++;
  endtask

  task automatic step();
    exp_t e;
    bit   haz;
    haz = ex_is_load && ex_we && (ex_waddr != 5'd0)
       && ((id_re1 && id_raddr1 == ex_waddr)
        || (id_re2 && id_raddr2 == ex_waddr));
    model(0, rst_n, haz, ex_div_req, div_ready, flush, e);
    q0.push_back(e);
    model(1, rst_n, haz, ex_div_req, div_ready, flush, e);
    q1.push_back(e);
    ncyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    id_re1 = 0; id_raddr1 = 0; id_re2 = 0; id_raddr2 = 0;
    ex_we = 0; ex_waddr = 0; ex_is_load = 0;
    ex_div_req = 0; div_ready = 0; flush = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, mcyc, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q0.size() > 0 && q1.size() > 0) begin
        a = q0.pop_front();
        b = q1.pop_front();
        chk("stall0",  32'(stall0), 32'(a.stall));
        chk("start0",  32'(st0),    32'(a.start));
        chk("cancel0", 32'(cn0),    32'(a.cancel));
        chk("err0",    32'(er0),    32'(a.err));
        chk("stall1",  32'(stall1), 32'(b.stall));
        chk("start1",  32'(st1),    32'(b.start));
        chk("cancel1", 32'(cn1),    32'(b.cancel));
        chk("err1",    32'(er1),    32'(b.err));
`ifdef STALL_PERF_EN
        chk("perf_load0", pl0, 32'(a.pl));
        chk("perf_div0",  pd0, 32'(a.pd));
        chk("perf_load1", pl1, 32'(b.pl));
        chk("perf_div1",  pd1, 32'(b.pd));
`endif
        mcyc++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", ncyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear();
    @(posedge clk);
    #1;
    step();
    step();
    rst_n = 1'b1;
    step();

    // load-use through port 2
    ex_is_load = 1; ex_we = 1; ex_waddr = 5'd5;
    id_re2 = 1; id_raddr2 = 5'd5;
    step();
    clear();
    repeat (3) step();

    // load to $0 never stalls
    ex_is_load = 1; ex_we = 1; ex_waddr = 5'd0;
    id_re1 = 1; id_re2 = 1;
    step();
    clear();
    repeat (3) step();

    // divide finishing 33 cycles after the request
    ex_div_req = 1;
    repeat (33) step();
    div_ready = 1;
    step();
    clear();
    repeat (3) step();

    // divide flushed, late ready ignored
    ex_div_req = 1;
    repeat (10) step();
    flush = 1;
    step();
    clear();
    repeat (4) step();
    div_ready = 1;
    step();
    clear();
    step();

    // divide timeout, sticky err
    ex_div_req = 1;
    step();
    clear();
    repeat (45) step();

    // async reset during a divide
    ex_div_req = 1;
    repeat (6) step();
    rst_n = 1'b0;
    ex_is_load = 1; ex_we = 1; ex_waddr = 5'd3;
    id_re1 = 1; id_raddr1 = 5'd3;
    step();
    step();
    rst_n = 1'b1;
    clear();
    repeat (3) step();

    repeat (4000) begin
      rst_n      = ($urandom_range(0, 999) != 0);
      ex_is_load = 1'($urandom_range(0, 1));
      ex_we      = ($urandom_range(0, 3) != 0);
      ex_waddr   = 5'($urandom_range(0, 3));
      id_re1     = 1'($urandom_range(0, 1));
      id_raddr1  = 5'($urandom_range(0, 3));
      id_re2     = 1'($urandom_range(0, 1));
      id_raddr2  = 5'($urandom_range(0, 3));
      ex_div_req = ($urandom_range(0, 15) == 0);
      div_ready  = ($urandom_range(0, 30) == 0);
      flush      = ($urandom_range(0, 40) == 0);
      step();
    end
    rst_n = 1'b1;
    clear();
    repeat (2) step();

    repeat (2) @(negedge clk);
    #1;
    chk("drain", 32'(q0.size() + q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stall_ctrl.md
Name: stall_ctrl

Overview:
Pipeline stall controller for the 5-stage core. It stops the ID stage from reading a load result that the regfile bypass network cannot yet supply (load-use). It also sequences multi-cycle divides in EX: it starts the divider, freezes the pipe until the divider finishes, and handles timeout and flush. It drives the 6-bit stall vector consumed by PC, IF/ID, ID/EX, EX/MEM, MEM/WB and WB.

Parameters:
LOAD_BUBBLES, 1, number of stall cycles inserted per load-use hazard (1..7).
DIV_TIMEOUT, 40, max cycles in DIV_BUSY before forced abort (must be >= 33).
CNT_W, 6, width of the internal cycle counter; must hold DIV_TIMEOUT.

Ports:
clk  in  1  core clock.
rst_n  in  1  asynchronous active-low reset.
id_re1  in  1  ID reads port 1.
id_raddr1  in  5  ID read address 1.
id_re2  in  1  ID reads port 2.
id_raddr2  in  5  ID read address 2.
ex_we  in  1  EX instruction writes the regfile (bus bit 37).
ex_waddr  in  5  EX destination (bus bits 36:32).
ex_is_load  in  1  EX instruction is a load.
ex_div_req  in  1  EX instruction is DIV/DIVU.
div_ready  in  1  divider result valid, 1-cycle pulse.
flush  in  1  exception/eret flush from MEM.
stall  out  6  [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB; 1 = hold.
div_start  out  1  1-cycle divider start pulse.
div_cancel  out  1  1-cycle divider abort pulse.
div_err  out  1  sticky timeout flag; cleared by reset only.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, div_err=0. stall=0, div_start=0, div_cancel=0 (outputs decoded from reset state).
- FSM states: IDLE, LOAD_WAIT, DIV_BUSY.
- hazard = ex_is_load & ex_we & (ex_waddr!=0) & ((id_re1 & id_raddr1==ex_waddr) | (id_re2 & id_raddr2==ex_waddr)).
- stall is combinational from state and inputs; zero cycles of added latency.
- Priority in every state: flush > div > load-use.
- IDLE:
  - flush: stall=0, no transition.
  - ex_div_req: div_start=1, stall=6'b001111, next DIV_BUSY, counter=0.
  - else hazard: stall=6'b000111 (bubble into ID/EX). If LOAD_BUBBLES>1, next LOAD_WAIT with counter=LOAD_BUBBLES-1; otherwise stay IDLE.
  - else stall=0.
- LOAD_WAIT:
  - stall=6'b000111; counter decrements each cycle.
  - At counter==1, next IDLE.
  - hazard is ignored while in LOAD_WAIT.
  - flush: stall=0, next IDLE.
- DIV_BUSY:
  - stall=6'b001111; counter increments each cycle.
  - div_ready: stall=0 in that same cycle (result captured into EX/MEM), next IDLE.
  - flush: div_cancel=1, stall=0, next IDLE; a div_ready arriving in the same cycle is discarded.
  - counter==DIV_TIMEOUT-1 without div_ready: div_cancel=1, div_err<=1, stall=0, next IDLE.
- div_start asserts only on the IDLE->DIV_BUSY transition. A div_ready outside DIV_BUSY is ignored.
- Counter saturates and never wraps; width checked against DIV_TIMEOUT at elaboration.
- Reset mid-DIV_BUSY: immediate IDLE, no div_cancel pulse; the divider is reset by the same rst_n.

Optional Feature:
STALL_PERF_EN:
- Defined: adds outputs perf_load_cyc[31:0] and perf_div_cyc[31:0]. They count cycles with load-use stall and div stall respectively. Saturating at 32'hFFFFFFFF, cleared by reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package: state encodings (IDLE=2'd0, LOAD_WAIT=2'd1, DIV_BUSY=2'd2), and stall vector constants STALL_NONE, STALL_LOAD=6'b000111, STALL_DIV=6'b001111.
- Reuse the existing bus width define (38) for the EX bus field split.
- One sub-module, hazard_detect: purely combinational load-use compare, reusable by a future dual-issue ID.

Test Plan:
- lw $5 in EX, ID reads $5 via port2, LOAD_BUBBLES=1 -> stall=000111 one cycle, then 000000, no FSM state change.
- lw $0 in EX, ID reads $0 -> stall=000000 (zero register exempt).
- ex_div_req=1, div_ready pulsed 33 cycles later -> div_start one cycle, stall=001111 for 33 cycles, 000000 on the ready cycle.
- DIV_BUSY, flush at cycle 10 -> div_cancel=1, stall=0, IDLE next; late div_ready ignored.
- DIV_BUSY, no div_ready, DIV_TIMEOUT=40 -> div_cancel at cycle 39, div_err=1 and stays 1.
- rst_n low mid-DIV_BUSY -> stall=0 immediately (asynchronous), IDLE after release, no div_cancel.
